// File: rtl/stopwatch_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_input_pkg
//  Purpose  : Shared constants for the stopwatch input front-end: button
//             conditioner state codes, default timing values and the mode
//             encodings shared with the stopwatch core.
//  Revision : 1.0  initial release
// ============================================================================
package stopwatch_input_pkg;

    // Button conditioner state codes (shared with debug tooling / LEDs)
    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] PRESS_WAIT   = 3'd1;
    localparam logic [2:0] PULSE        = 3'd2;
    localparam logic [2:0] HELD         = 3'd3;
    localparam logic [2:0] RELEASE_WAIT = 3'd4;

    // Default timing: 50000 cycles of debounce, 4-cycle output pulses
    localparam logic [15:0] DB_CYC_DEF    = 16'd50000;
    localparam logic [7:0]  PULSE_CYC_DEF = 8'd4;
    localparam int          CW_DEF        = 16;

    // Mode switch encodings understood by the stopwatch core
    typedef enum logic [1:0] {
        MODE_0 = 2'b00,
        MODE_1 = 2'b01,
        MODE_2 = 2'b10,
        MODE_3 = 2'b11
    } mode_e;

endpackage
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Synchronises one raw push-button, debounces press and release,
//             and emits exactly one PULSE_CYC-long pulse per press.
//  Revision : 1.0  initial release
// ============================================================================
module button_conditioner
    import stopwatch_input_pkg::*;
#(
    parameter logic [15:0] DB_CYC    = DB_CYC_DEF,
    parameter logic [7:0]  PULSE_CYC = PULSE_CYC_DEF,
    parameter int          CW        = CW_DEF
) (
    input  logic       c_clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       pulse,
    output logic [2:0] state
);

    localparam logic [CW-1:0] c_db_last    = CW'(DB_CYC - 16'd1);
    localparam logic [CW-1:0] c_pulse_last = CW'(PULSE_CYC - 8'd1);
    localparam logic [CW-1:0] c_one        = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;

    // Two-flop synchroniser: the raw button is asynchronous to c_clk
    always_ff @(posedge c_clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Press/release debounce FSM; the counter never runs past its terminal value
    always_ff @(posedge c_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (r_sync2) begin
                        r_state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sync2) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_db_last) begin
                        r_state <= PULSE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                PULSE: begin
                    if (r_cnt == c_pulse_last) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                HELD: begin
                    r_cnt <= '0;
                    if (!r_sync2) begin
                        r_state <= RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync2) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_db_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pulse = (r_state == PULSE);
    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/stopwatch_input.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_input
//  Purpose  : Board-pin front-end for the stopwatch: clean R/P pulses from the
//             push-buttons (R wins over P) and debounced sel/load switches.
//  Revision : 1.0  initial release
// ============================================================================
module stopwatch_input
    import stopwatch_input_pkg::*;
#(
    parameter logic [15:0] DB_CYC    = DB_CYC_DEF,
    parameter logic [7:0]  PULSE_CYC = PULSE_CYC_DEF,
    parameter int          CW        = CW_DEF
) (
    input  logic       c_clk,
    input  logic       rst,
    input  logic       btn_r,
    input  logic       btn_p,
    input  logic [1:0] sw_sel,
    input  logic [7:0] sw_load,
    output logic       R,
    output logic       P,
    output logic [1:0] sel,
    output logic [7:0] load,
    output logic       busy
);

    localparam logic [CW-1:0] c_db_last = CW'(DB_CYC - 16'd1);
    localparam logic [CW-1:0] c_one     = CW'(1);

    logic       w_r_pulse;
    logic       w_p_pulse;
    logic [2:0] w_r_state;
    logic [2:0] w_p_state;
    logic       r_p_sup;

    logic [9:0]    r_sw_sync1;
    logic [9:0]    r_sw_sync2;
    logic [9:0]    r_sw_cand;
    logic [CW-1:0] r_sw_cnt;
    logic [9:0]    r_sw_out;

    button_conditioner #(
        .DB_CYC    (DB_CYC),
        .PULSE_CYC (PULSE_CYC),
        .CW        (CW)
    ) u_btn_r (
        .c_clk   (c_clk),
        .rst     (rst),
        .btn_raw (btn_r),
        .pulse   (w_r_pulse),
        .state   (w_r_state)
    );

    button_conditioner #(
        .DB_CYC    (DB_CYC),
        .PULSE_CYC (PULSE_CYC),
        .CW        (CW)
    ) u_btn_p (
        .c_clk   (c_clk),
        .rst     (rst),
        .btn_raw (btn_p),
        .pulse   (w_p_pulse),
        .state   (w_p_state)
    );

    // Once R has overlapped a P pulse, keep P masked until that pulse ends
    always_ff @(posedge c_clk) begin
        if (rst) begin
            r_p_sup <= 1'b0;
        end else begin
            r_p_sup <= w_p_pulse & (w_r_pulse | r_p_sup);
        end
    end

    assign R = w_r_pulse;
    assign P = w_p_pulse & ~w_r_pulse & ~r_p_sup;

    // Switch vector synchroniser, two flops like the buttons
    always_ff @(posedge c_clk) begin
        if (rst) begin
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
        end else begin
            r_sw_sync1 <= {sw_sel, sw_load};
            r_sw_sync2 <= r_sw_sync1;
        end
    end

    // Debounce sel+load as one vector so both fields always update together
    always_ff @(posedge c_clk) begin
        if (rst) begin
            r_sw_cand <= '0;
            r_sw_cnt  <= '0;
            r_sw_out  <= {MODE_0, 8'h00};
        end else if (r_sw_sync2 != r_sw_cand) begin
            r_sw_cand <= r_sw_sync2;
            r_sw_cnt  <= '0;
        end else if (r_sw_cnt == c_db_last) begin
            r_sw_out <= r_sw_cand;
        end else begin
            r_sw_cnt <= r_sw_cnt + c_one;
        end
    end

    assign sel  = r_sw_out[9:8];
    assign load = r_sw_out[7:0];
    assign busy = (w_r_state != IDLE) | (w_p_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_input.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_input
//  Purpose  : Self-checking bench for stopwatch_input (DB_CYC=4, PULSE_CYC=2):
//             vector table, directed corner sequences and random stimulus
//             against a run-length reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_input;

    localparam int DBI = 4;
    localparam int PCI = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_r = 1'b0;
    logic       btn_p = 1'b0;
    logic [1:0] sw_sel = 2'b00;
    logic [7:0] sw_load = 8'h00;
    logic       R, P, busy;
    logic [1:0] sel;
    logic [7:0] load;

    always #5 clk = ~clk;

    stopwatch_input #(
        .DB_CYC    (16'd4),
        .PULSE_CYC (8'd2),
        .CW        (8)
    ) dut (
        .c_clk   (clk),
        .rst     (rst),
        .btn_r   (btn_r),
        .btn_p   (btn_p),
        .sw_sel  (sw_sel),
        .sw_load (sw_load),
        .R       (R),
        .P       (P),
        .sel     (sel),
        .load    (load),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: delay lines for synchronisers, run lengths for debounce
    bit         m_s1[2], m_s2[2], m_armed[2];
    int         m_run[2], m_left[2];
    bit         m_veto;
    logic [9:0] m_sw1, m_sw2, m_prev, m_out;
    int         m_swrun;
    bit         eR, eP, eBusy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit raw[2];
        bit x;
        logic [9:0] xs;
        raw[0] = btn_r;
        raw[1] = btn_p;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_armed[b] = 1; m_run[b] = 0; m_left[b] = 0;
            end
            m_veto = 0;
            m_sw1 = '0; m_sw2 = '0; m_prev = '0; m_out = '0; m_swrun = 1;
        end else begin
            for (int b = 0; b < 2; b++) begin
                x = m_s2[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
                if (m_armed[b]) begin
                    // armed: need DB+1 consecutive synced ones to fire
                    if (x) begin
                        m_run[b]++;
                        if (m_run[b] == DBI + 1) begin
                            m_armed[b] = 0; m_run[b] = 0; m_left[b] = PCI;
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                end else if (m_left[b] > 0) begin
                    m_left[b]--;
                end else begin
                    // disarmed: need DB+1 consecutive synced zeros to re-arm
                    if (!x) begin
                        m_run[b]++;
                        if (m_run[b] == DBI + 1) begin
                            m_armed[b] = 1; m_run[b] = 0;
                        end
                    end else begin
                        m_run[b] = 0;
                    end
                end
            end
            xs = m_sw2;
            m_sw2 = m_sw1;
            m_sw1 = {sw_sel, sw_load};
            if (xs == m_prev) begin
                if (m_swrun <= DBI) m_swrun++;
            end else begin
                m_prev = xs;
                m_swrun = 1;
            end
            if (m_swrun >= DBI + 1) m_out = m_prev;
        end
        eR = (m_left[0] > 0);
        if (m_left[1] == 0) m_veto = 0;
        else if (eR) m_veto = 1;
        eP = (m_left[1] > 0) && !m_veto;
        eBusy = !m_armed[0] || (m_run[0] > 0) || !m_armed[1] || (m_run[1] > 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", 32'({R, P, sel, load, busy}), 32'({eR, eP, m_out, eBusy}));
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        bit         rs, br, bp;
        logic [1:0] ss;
        logic [7:0] sl;
        int         n;
        bit         eR, eP;
        logic [1:0] esel;
        logic [7:0] eload;
        bit         ebusy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- vector table ----------------
        tbl.push_back('{1, 0, 0, 2'd0, 8'h00, 3,  0, 0, 2'd0, 8'h00, 0});
        tbl.push_back('{0, 0, 0, 2'd3, 8'h25, 6,  0, 0, 2'd0, 8'h00, 0});
        tbl.push_back('{0, 0, 0, 2'd3, 8'h25, 1,  0, 0, 2'd3, 8'h25, 0});
        tbl.push_back('{0, 0, 0, 2'd3, 8'h35, 2,  0, 0, 2'd3, 8'h25, 0});
        tbl.push_back('{0, 0, 0, 2'd3, 8'h25, 10, 0, 0, 2'd3, 8'h25, 0});
        tbl.push_back('{0, 1, 1, 2'd3, 8'h25, 7,  1, 0, 2'd3, 8'h25, 1});
        tbl.push_back('{0, 1, 1, 2'd3, 8'h25, 1,  1, 0, 2'd3, 8'h25, 1});
        tbl.push_back('{0, 1, 1, 2'd3, 8'h25, 1,  0, 0, 2'd3, 8'h25, 1});
        tbl.push_back('{0, 0, 0, 2'd3, 8'h25, 6,  0, 0, 2'd3, 8'h25, 1});
        tbl.push_back('{0, 0, 0, 2'd3, 8'h25, 1,  0, 0, 2'd3, 8'h25, 0});
        tbl.push_back('{0, 0, 1, 2'd3, 8'h25, 7,  0, 1, 2'd3, 8'h25, 1});
        tbl.push_back('{0, 0, 1, 2'd3, 8'h25, 1,  0, 1, 2'd3, 8'h25, 1});
        tbl.push_back('{0, 0, 1, 2'd3, 8'h25, 1,  0, 0, 2'd3, 8'h25, 1});
        tbl.push_back('{0, 0, 0, 2'd3, 8'h25, 7,  0, 0, 2'd3, 8'h25, 0});

        foreach (tbl[i]) begin
            rst = tbl[i].rs; btn_r = tbl[i].br; btn_p = tbl[i].bp;
            sw_sel = tbl[i].ss; sw_load = tbl[i].sl;
            hold(tbl[i].n);
            check($sformatf("vec%0d", i), 32'({R, P, sel, load, busy}),
                  32'({tbl[i].eR, tbl[i].eP, tbl[i].esel, tbl[i].eload, tbl[i].ebusy}));
        end

        // ---------------- reset with every raw input high ----------------
        rst = 1; btn_r = 1; btn_p = 1; sw_sel = 2'd3; sw_load = 8'hff;
        for (int k = 0; k < 3; k++) begin
            step();
            check("reset_outputs", 32'({R, P, sel, load, busy}), 32'd0);
        end
        rst = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("reset_R_pulse", 32'(R), 32'(k == 7 || k == 8));
            check("reset_P_supp", 32'(P), 32'd0);
        end
        btn_r = 0; btn_p = 0;
        hold(12);

        // ---------------- clean 40-cycle press ----------------
        btn_p = 1;
        for (int k = 1; k <= 40; k++) begin
            step();
            check("clean_P", 32'(P), 32'(k == 7 || k == 8));
        end
        btn_p = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("clean_release", 32'({P, busy}), 32'({1'b0, 1'(k < 7)}));
        end

        // ---------------- bouncy press and release ----------------
        for (int k = 1; k <= 25; k++) begin
            btn_p = (k <= 4) ? 1'(k % 2) : 1'b1;
            step();
            check("bounce_P", 32'(P), 32'(k == 11 || k == 12));
        end
        for (int k = 1; k <= 15; k++) begin
            btn_p = (k == 2);
            step();
            check("bounce_release_P", 32'(P), 32'd0);
        end
        check("bounce_idle", 32'(busy), 32'd0);

        // ---------------- reset in the middle of a P pulse ----------------
        btn_p = 1;
        hold(7);
        check("midrst_P_before", 32'(P), 32'd1);
        rst = 1;
        step();
        check("midrst_P_cut", 32'(P), 32'd0);
        rst = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("midrst_P_again", 32'(P), 32'(k == 7 || k == 8));
        end
        btn_p = 0;
        hold(10);

        // ---------------- random stimulus against the model ----------------
        begin
            int rh = 0;
            int ph = 0;
            for (int c = 0; c < 3000; c++) begin
                if (rh == 0) begin
                    btn_r = 1'($urandom_range(0, 1));
                    rh = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 16));
                end else begin
                    rh--;
                end
                if (ph == 0) begin
                    btn_p = 1'($urandom_range(0, 1));
                    ph = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 16));
                end else begin
                    ph--;
                end
                if ($urandom_range(0, 19) == 0) begin
                    sw_sel  = 2'($urandom_range(0, 3));
                    sw_load = 8'($urandom_range(0, 255));
                end
                rst = ($urandom_range(0, 299) == 0);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
